// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences the CPU through reset, run and stop, with cycle budget and halt-on-PC-repeat.
// Optional single-step support is compiled in with `define RUN_CTRL_STEP_EN.
module cpu_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int unsigned HALT_REPEAT = 3,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
`ifdef RUN_CTRL_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_rst_n,
    output logic             cpu_en,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SCW = $clog2(HALT_REPEAT + 1);
    localparam logic [RCW-1:0]   RST_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [SCW-1:0]   HALT_LAST = SCW'(HALT_REPEAT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [RCW-1:0]   rst_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_d;
    logic [SCW-1:0]   same_cnt_q;
    logic [SCW-1:0]   same_cnt_d;
    logic [PC_W-1:0]  pc_prev_q;
    logic             pc_valid_q;
    logic             halted_q;
    logic             timeout_q;
    logic             run_en;
    logic             pc_eq;
    logic             halt_hit;
    logic             tmo_hit;

`ifdef RUN_CTRL_STEP_EN
    logic step_q;
    logic mode_q;

    // Step inputs are registered so cpu_en never depends combinationally on a port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            step_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            step_q <= step;
            mode_q <= step_mode;
        end
    end

    assign run_en = !mode_q || step_q;
`else
    assign run_en = 1'b1;
`endif

    assign pc_eq       = pc_valid_q && (pc == pc_prev_q);
    assign halt_hit    = pc_eq && (same_cnt_q == HALT_LAST);
    assign tmo_hit     = (cycle_cnt_q == CNT_LAST);
    assign cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    assign same_cnt_d  = pc_eq ? same_cnt_q + SCW'(1) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            same_cnt_q  <= '0;
            pc_prev_q   <= '0;
            pc_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else if (abort) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            same_cnt_q  <= '0;
            pc_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_RESET;
                        rst_cnt_q   <= '0;
                        cycle_cnt_q <= '0;
                        same_cnt_q  <= '0;
                        pc_valid_q  <= 1'b0;
                        halted_q    <= 1'b0;
                        timeout_q   <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q <= S_RUN;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RCW'(1);
                    end
                end
                S_RUN: begin
                    if (run_en) begin
                        cycle_cnt_q <= cycle_cnt_d;
                        pc_prev_q   <= pc;
                        pc_valid_q  <= 1'b1;
                        same_cnt_q  <= same_cnt_d;
                        // Halt wins when it lands on the same cycle as the budget expiring.
                        if (halt_hit) begin
                            state_q  <= S_DONE;
                            halted_q <= 1'b1;
                        end else if (tmo_hit) begin
                            state_q   <= S_DONE;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_rst_n = (state_q == S_RUN) || (state_q == S_DONE);
    assign cpu_en    = (state_q == S_RESET) || ((state_q == S_RUN) && run_en);
    assign busy      = (state_q == S_RESET) || (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign halted    = halted_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: two instances (budget 10 and budget 4) share stimulus and are
// checked cycle by cycle against a run-level model that scans the presented PC sequence.
module tb_cpu_run_ctrl;

    localparam int RST   = 2;
    localparam int MAX_A = 10;
    localparam int MAX_B = 4;
    localparam int HREP  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] pc = '0;
`ifdef RUN_CTRL_STEP_EN
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
`endif

    logic        rst_n_a, en_a, busy_a, done_a, halt_a, tmo_a;
    logic        rst_n_b, en_b, busy_b, done_b, halt_b, tmo_b;
    logic [31:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_errors = 0;
    int seq [0:63];

    always #5 clk = ~clk;

    cpu_run_ctrl #(.RST_CYCLES(RST), .MAX_CYCLES(MAX_A), .HALT_REPEAT(HREP)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef RUN_CTRL_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .pc(pc), .cpu_rst_n(rst_n_a), .cpu_en(en_a), .busy(busy_a), .done(done_a),
        .halted(halt_a), .timeout(tmo_a), .cycle_cnt(cnt_a)
    );

    cpu_run_ctrl #(.RST_CYCLES(RST), .MAX_CYCLES(MAX_B), .HALT_REPEAT(HREP)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef RUN_CTRL_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .pc(pc), .cpu_rst_n(rst_n_b), .cpu_en(en_b), .busy(busy_b), .done(done_b),
        .halted(halt_b), .timeout(tmo_b), .cycle_cnt(cnt_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Run outcome straight from the rules: halt once HREP+1 consecutive PCs match,
    // otherwise stop when the budget is used up; halt is tested first.
    function automatic void model_run(input int max_c, output int n, output logic h, output logic t);
        bit all_eq;
        h = 1'b0;
        t = 1'b0;
        n = max_c;
        for (int i = 1; i <= max_c; i++) begin
            if (i > HREP) begin
                all_eq = 1'b1;
                for (int j = i - HREP; j < i; j++)
                    if (seq[j] != seq[i]) all_eq = 1'b0;
                if (all_eq) begin
                    h = 1'b1;
                    n = i;
                    return;
                end
            end
            if (i == max_c) begin
                t = 1'b1;
                n = i;
                return;
            end
        end
    endfunction

    // {cpu_rst_n, cpu_en, busy, done, halted, timeout} after edge start+e.
    function automatic logic [31:0] exp_status(input int e, input int n, input logic h, input logic t);
        if (e < RST)          return 32'b011000;
        else if (e < RST + n) return 32'b111000;
        else                  return {26'd0, 4'b1001, h, t};
    endfunction

    function automatic logic [31:0] exp_cnt(input int e, input int n);
        if (e < RST)          return 32'd0;
        else if (e < RST + n) return 32'(e - RST);
        else                  return 32'(n);
    endfunction

    function automatic logic [31:0] stat_a();
        return {26'd0, rst_n_a, en_a, busy_a, done_a, halt_a, tmo_a};
    endfunction

    function automatic logic [31:0] stat_b();
        return {26'd0, rst_n_b, en_b, busy_b, done_b, halt_b, tmo_b};
    endfunction

    task automatic check_idle(input string tag);
        check_val({tag, "_stat_a"}, stat_a(), 32'd0);
        check_val({tag, "_cnt_a"}, cnt_a, 32'd0);
        check_val({tag, "_stat_b"}, stat_b(), 32'd0);
        check_val({tag, "_cnt_b"}, cnt_b, 32'd0);
    endtask

    task automatic gen_seq(input int kind);
        for (int i = 0; i < 64; i++) begin
            case (kind)
                0: seq[i] = 32'h100 + 4 * i;
                1: seq[i] = 32'h40;
                2: seq[i] = (i < 3) ? 32'h10 + 4 * i : 32'h1C;
                default: seq[i] = (i > 0 && $urandom_range(0, 99) < 65) ? seq[i - 1]
                                                                         : 4 * $urandom_range(0, 7);
            endcase
        end
    endtask

    task automatic run_seq(input int id, input int kind);
        int na, nb, last, nmin;
        logic ha, ta, hb, tb;
        gen_seq(kind);
        model_run(MAX_A, na, ha, ta);
        model_run(MAX_B, nb, hb, tb);
        nmin = (na < nb) ? na : nb;
        last = RST + ((na > nb) ? na : nb) + 1;
        pc = $urandom;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 0; e <= last; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            check_val("stat_a", stat_a(), exp_status(e, na, ha, ta));
            check_val("cnt_a", cnt_a, exp_cnt(e, na));
            check_val("stat_b", stat_b(), exp_status(e, nb, hb, tb));
            check_val("cnt_b", cnt_b, exp_cnt(e, nb));
            pc = (e >= RST) ? seq[e - RST + 1] : $urandom;
            // Stray start pulses while both instances are busy must be ignored.
            start = (kind == 3 && e < RST + nmin && $urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        $display("run %0d kind %0d: a cycles=%0d halted=%0b timeout=%0b | b cycles=%0d halted=%0b timeout=%0b",
                 id, kind, cnt_a, halt_a, tmo_a, cnt_b, halt_b, tmo_b);
    endtask

    // Abort (or reset) sampled at the end of RUN cycle 3.
    task automatic run_interrupt(input bit use_reset);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 0; e < RST + 2; e++) begin
            pc = 32'h200 + 4 * e;
            @(posedge clk); #1;
        end
        check_val("pre_int_cnt_a", cnt_a, 32'd2);
        if (use_reset) reset = 1'b0;
        else           abort = 1'b1;
        start = 1'b1;
        pc = 32'h300;
        @(posedge clk); #1;
        reset = 1'b1;
        abort = 1'b0;
        start = 1'b0;
        check_idle(use_reset ? "reset_mid" : "abort_mid");
        @(posedge clk); #1;
        check_idle(use_reset ? "reset_hold" : "abort_hold");
        $display("interrupt via %s: a cycles=%0d rst_n=%0b | b cycles=%0d rst_n=%0b",
                 use_reset ? "reset" : "abort", cnt_a, rst_n_a, cnt_b, rst_n_b);
    endtask

`ifdef RUN_CTRL_STEP_EN
    task automatic run_step();
        int en_cycles;
        en_cycles = 0;
        step_mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 0; e <= RST + 18; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            if (rst_n_a && en_a) en_cycles++;
            pc = 32'h400 + 4 * e;
            step = (e == RST + 1) || (e == RST + 6) || (e == RST + 11);
        end
        step = 1'b0;
        check_val("step_en_cycles", 32'(en_cycles), 32'd3);
        check_val("step_cnt_a", cnt_a, 32'd3);
        check_val("step_cnt_b", cnt_b, 32'd3);
        check_val("step_busy_a", {31'd0, busy_a}, 32'd1);
        $display("step run: enables=%0d a cycles=%0d b cycles=%0d", en_cycles, cnt_a, cnt_b);
        abort = 1'b1;
        step_mode = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("idle");

        run_seq(0, 0);   // timeout on both budgets
        run_seq(1, 1);   // constant PC: halt at 4, coinciding with budget 4
        run_seq(2, 2);   // halt after PC settles on 0x1C
        run_interrupt(1'b0);
        run_seq(3, 0);
        run_interrupt(1'b1);
        for (int r = 0; r < 16; r++) run_seq(4 + r, 3);
`ifdef RUN_CTRL_STEP_EN
        run_step();
        run_seq(20, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
